mac_dot_accumulator: RTL

- Pipelined unsigned multiply-accumulate stage that sits directly downstream of the matrix-operand memories A and B (8-bit) and directly upstream of result memory C (22-bit).
- Consumes one A/B operand pair per valid cycle and accumulates N_LEN products into one dot-product result.
- Emits each result with its C write address and active-low memory strobes, for a 64x64 x 64x64 matrix product (4096 results).

---
 rtl/mac_dot_accumulator.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mac_dot_accumulator.sv
// Two-stage unsigned multiply-accumulate feeding result memory C.
// Stage 1 registers the operand product and stage 2 sums N_LEN products into one result.
module mac_dot_accumulator #(
    parameter int D_W    = 8,
    parameter int ACC_W  = 22,
    parameter int N_LEN  = 64,
    parameter int N_RES  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [D_W-1:0]    in_a,
    input  logic [D_W-1:0]    in_b,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    output logic [ADDR_W-1:0] c_addr,
    output logic              c_nwrt,
    output logic              c_nce,
    output logic              done
);

    localparam int CNT_W = (N_LEN > 1) ? $clog2(N_LEN) : 1;
    localparam logic [CNT_W-1:0]  ELEM_LAST = CNT_W'(N_LEN - 1);
    localparam logic [ADDR_W-1:0] RES_LAST  = ADDR_W'(N_RES - 1);

    logic [CNT_W-1:0]   elem_cnt_q, elem_cnt_d;
    logic [ADDR_W-1:0]  res_cnt_q,  res_cnt_d;
    logic [2*D_W-1:0]   prod_q,     prod_d;
    logic               p_vld_q,    p_vld_d;
    logic               p_first_q,  p_first_d;
    logic               p_last_q,   p_last_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]  c_addr_q,   c_addr_d;
    logic               c_nwrt_q,   c_nwrt_d;
    logic               c_nce_q,    c_nce_d;
    logic               done_q,     done_d;

    logic               accept_s;
    logic               issue_s;
    logic [ACC_W-1:0]   sum_s;

    // Next-state logic for the counters, both pipeline stages and the memory strobes
    always_comb begin
        accept_s    = in_valid & ~done_q & ~clear;
        sum_s       = p_first_q ? ACC_W'(prod_q) : (acc_q + ACC_W'(prod_q));
        issue_s     = p_vld_q & p_last_q & ~clear;

        elem_cnt_d  = elem_cnt_q;
        res_cnt_d   = res_cnt_q;
        prod_d      = prod_q;
        p_vld_d     = accept_s;
        p_first_d   = p_first_q;
        p_last_d    = p_last_q;
        acc_d       = acc_q;
        out_valid_d = issue_s;
        out_data_d  = out_data_q;
        c_addr_d    = c_addr_q;
        done_d      = done_q;

        if (accept_s) begin
            prod_d    = in_a * in_b;
            p_first_d = (elem_cnt_q == {CNT_W{1'b0}});
            p_last_d  = (elem_cnt_q == ELEM_LAST);
            if (elem_cnt_q == ELEM_LAST) begin
                elem_cnt_d = {CNT_W{1'b0}};
            end else begin
                elem_cnt_d = elem_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            elem_cnt_d = elem_cnt_q;
        end

        if (p_vld_q) begin
            acc_d = sum_s;
        end else begin
            acc_d = acc_q;
        end

        // c_addr latches the index as the result issues; the counter advances one cycle later
        if (issue_s) begin
            out_data_d = sum_s;
            c_addr_d   = res_cnt_q;
        end else begin
            out_data_d = out_data_q;
            c_addr_d   = c_addr_q;
        end

        if (out_valid_q) begin
            if (res_cnt_q == RES_LAST) begin
                res_cnt_d = {ADDR_W{1'b0}};
                done_d    = 1'b1;
            end else begin
                res_cnt_d = res_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            res_cnt_d = res_cnt_q;
        end

        if (clear) begin
            elem_cnt_d = {CNT_W{1'b0}};
            res_cnt_d  = {ADDR_W{1'b0}};
            c_addr_d   = {ADDR_W{1'b0}};
            done_d     = 1'b0;
            p_vld_d    = 1'b0;
        end else begin
            p_vld_d    = accept_s;
        end

        c_nwrt_d = ~out_valid_d;
        c_nce_d  = ~out_valid_d;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            elem_cnt_q  <= {CNT_W{1'b0}};
            res_cnt_q   <= {ADDR_W{1'b0}};
            prod_q      <= {(2*D_W){1'b0}};
            p_vld_q     <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
            c_addr_q    <= {ADDR_W{1'b0}};
            c_nwrt_q    <= 1'b1;
            c_nce_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            elem_cnt_q  <= elem_cnt_d;
            res_cnt_q   <= res_cnt_d;
            prod_q      <= prod_d;
            p_vld_q     <= p_vld_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            c_addr_q    <= c_addr_d;
            c_nwrt_q    <= c_nwrt_d;
            c_nce_q     <= c_nce_d;
            done_q      <= done_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign c_addr    = c_addr_q;
    assign c_nwrt    = c_nwrt_q;
    assign c_nce     = c_nce_q;
    assign done      = done_q;

endmodule
